// File: rtl/emif_amm_arbiter.sv
// Two-port round-robin arbiter in front of the DDR3 EMIF Avalon-MM user port.
// Write bursts hold the grant until their last beat; read bursts are tagged
// in issue order so returning beats are routed to the port that asked.
module emif_amm_arbiter #(
  parameter int DATA_W   = 320,
  parameter int ADDR_W   = 25,
  parameter int BURST_W  = 7,
  parameter int BE_W     = 40,
  parameter int RD_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    rq_read,
  input  logic [1:0]                    rq_write,
  input  logic [2*ADDR_W-1:0]           rq_addr,
  input  logic [2*BURST_W-1:0]          rq_burstcnt,
  input  logic [2*DATA_W-1:0]           rq_wrdata,
  input  logic [2*BE_W-1:0]             rq_byteenable,
  output logic [1:0]                    rq_ready,
  output logic [DATA_W-1:0]             rq_rddata,
  output logic [1:0]                    rq_rddatavalid,
  input  logic                          amm_ready,
  output logic                          amm_read,
  output logic                          amm_write,
  output logic [ADDR_W-1:0]             amm_address,
  output logic [BURST_W-1:0]            amm_burstcount,
  output logic [DATA_W-1:0]             amm_writedata,
  output logic [BE_W-1:0]               amm_byteenable,
  input  logic [DATA_W-1:0]             amm_readdata,
  input  logic                          amm_readdatavalid,
  output logic [$clog2(RD_DEPTH):0]     rd_outstanding,
  output logic                          err_rd_unexp
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, WR_BURST} state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic                 owner_q, owner_d;
  logic [BURST_W-1:0]   beats_left_q, beats_left_d;
  logic [CW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [BURST_W-1:0]   head_cnt_q, head_cnt_d;
  logic                 err_q, err_d;
  logic                 mem_port_q [RD_DEPTH];
  logic                 mem_port_d [RD_DEPTH];
  logic [BURST_W-1:0]   mem_bc_q   [RD_DEPTH];
  logic [BURST_W-1:0]   mem_bc_d   [RD_DEPTH];

  logic [CW-1:0]        count;
  logic                 full, empty;
  logic [1:0]           elig;
  logic                 gnt, gnt_vld;
  logic                 head_port;
  logic [BURST_W-1:0]   head_bc, bc_norm;
  logic                 push, pop, rd_beat;

  assign count          = wptr_q - rptr_q;
  assign full           = (count == CW'(RD_DEPTH));
  assign empty          = (count == '0);
  assign rd_outstanding = count;
  assign err_rd_unexp   = err_q;
  assign rq_rddata      = amm_readdata;
  assign head_port      = mem_port_q[rptr_q[PW-1:0]];
  assign head_bc        = mem_bc_q[rptr_q[PW-1:0]];

  // Grant selection: locked to the burst owner, else round-robin over eligible ports
  always_comb begin
    elig    = rq_write | (rq_read & {2{~full}});
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    if (rst) begin
      gnt_vld = 1'b0;
    end else if (state_q == WR_BURST) begin
      gnt     = owner_q;
      gnt_vld = 1'b1;
    end else if (elig == 2'b11) begin
      gnt     = ~last_q;
      gnt_vld = 1'b1;
    end else if (elig[0]) begin
      gnt     = 1'b0;
      gnt_vld = 1'b1;
    end else if (elig[1]) begin
      gnt     = 1'b1;
      gnt_vld = 1'b1;
    end
  end

  // Master-side mux of the granted port; everything zero without a grant
  always_comb begin
    amm_read       = 1'b0;
    amm_write      = 1'b0;
    amm_address    = '0;
    amm_burstcount = '0;
    amm_writedata  = '0;
    amm_byteenable = '0;
    rq_ready       = '0;
    if (gnt_vld) begin
      amm_address    = gnt ? rq_addr[2*ADDR_W-1:ADDR_W]         : rq_addr[ADDR_W-1:0];
      amm_burstcount = gnt ? rq_burstcnt[2*BURST_W-1:BURST_W]   : rq_burstcnt[BURST_W-1:0];
      amm_writedata  = gnt ? rq_wrdata[2*DATA_W-1:DATA_W]       : rq_wrdata[DATA_W-1:0];
      amm_byteenable = gnt ? rq_byteenable[2*BE_W-1:BE_W]       : rq_byteenable[BE_W-1:0];
      amm_write      = gnt ? rq_write[1] : rq_write[0];
      if (state_q == IDLE)
        amm_read = ~amm_write & (gnt ? rq_read[1] : rq_read[0]);
      rq_ready = gnt ? {amm_ready, 1'b0} : {1'b0, amm_ready};
    end
  end

  // Read-return routing from the head tag; beats with no tag are flagged
  always_comb begin
    rd_beat        = ~rst & amm_readdatavalid & ~empty;
    rq_rddatavalid = rd_beat ? (head_port ? 2'b10 : 2'b01) : 2'b00;
    pop            = rd_beat & (head_cnt_q == head_bc - BURST_W'(1));
  end

  // Next-state for arbitration, write-burst lock and tag FIFO
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    head_cnt_d   = head_cnt_q;
    err_d        = err_q;
    mem_port_d   = mem_port_q;
    mem_bc_d     = mem_bc_q;
    push         = 1'b0;
    bc_norm      = (amm_burstcount == '0) ? BURST_W'(1) : amm_burstcount;

    if (state_q == IDLE) begin
      if (gnt_vld && amm_ready && (amm_read || amm_write)) begin
        last_d = gnt;
        if (amm_write) begin
          if (bc_norm > BURST_W'(1)) begin
            state_d      = WR_BURST;
            owner_d      = gnt;
            beats_left_d = bc_norm - BURST_W'(1);
          end
        end else begin
          push = 1'b1;
        end
      end
    end else if (amm_write && amm_ready) begin
      beats_left_d = beats_left_q - BURST_W'(1);
      if (beats_left_q == BURST_W'(1))
        state_d = IDLE;
    end

    if (push) begin
      mem_port_d[wptr_q[PW-1:0]] = gnt;
      mem_bc_d[wptr_q[PW-1:0]]   = bc_norm;
      wptr_d                     = wptr_q + CW'(1);
    end
    if (rd_beat)
      head_cnt_d = pop ? '0 : head_cnt_q + BURST_W'(1);
    if (pop)
      rptr_d = rptr_q + CW'(1);
    if (amm_readdatavalid && empty)
      err_d = 1'b1;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      beats_left_q <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      head_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      head_cnt_q   <= head_cnt_d;
      err_q        <= err_d;
    end
  end

  // Tag FIFO storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    mem_port_q <= mem_port_d;
    mem_bc_q   <= mem_bc_d;
  end

endmodule
